// File: rtl/memory_stage_pkg.sv
// memory_stage_pkg
//   Shared constants for the MEM stage: data word width, result-select
//   encodings, load/store FSM state codes, and the writeback result mux.
//   Imported by memory_stage_if, memory_stage_lsu_ctrl and memory_stage.
package memory_stage_pkg;

    localparam int WORD_SIZE = 32;

    // ResultSrc encodings; 2'b11 is reserved and treated as RES_ALU
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    // Load/store FSM state codes
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // Writeback result select
    function automatic logic [WORD_SIZE-1:0] resultMux(
        input logic [1:0]           sel,
        input logic [WORD_SIZE-1:0] aluVal,
        input logic [WORD_SIZE-1:0] memVal,
        input logic [WORD_SIZE-1:0] pc4Val
    );
        case (sel)
            RES_MEM: return memVal;
            RES_PC4: return pc4Val;
            default: return aluVal;
        endcase
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// memory_stage_if
//   Data-memory bus between the MEM stage (master) and the memory (slave).
//   dmem_req/dmem_we/dmem_addr/dmem_wdata : request side, driven by master
//   dmem_rdata/dmem_ready                 : response side, driven by slave
//   dmem_ready marks the cycle the access completes; it only counts while
//   dmem_req is high.
interface memory_stage_if;
    import memory_stage_pkg::*;

    logic                 dmem_req;
    logic                 dmem_we;
    logic [WORD_SIZE-1:0] dmem_addr;
    logic [WORD_SIZE-1:0] dmem_wdata;
    logic [WORD_SIZE-1:0] dmem_rdata;
    logic                 dmem_ready;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ready
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ready
    );

endinterface

// File: rtl/memory_stage_lsu_ctrl.sv
// memory_stage_lsu_ctrl
//   Load/store sequencer for the MEM stage: IDLE/WAIT FSM, wait-state
//   counter with timeout, bus request and stall/fault decode.
//   Ports:
//     clk, rst          clock, asynchronous active-high reset
//     memWrite          store in MEM
//     resultSrc         result select of the instruction in MEM (01 = load)
//     addrLow           low two address bits, for the alignment check
//     dmemReady         bus access completes this cycle
//     dmemReq           bus request (combinational, forced low by rst)
//     stall             hold upstream stages (combinational, forced low by rst)
//     complete          access finishes at this edge (W regs capture)
//     fault             access faults at this edge (misaligned or timed out)
module memory_stage_lsu_ctrl
    import memory_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       memWrite,
    input  logic [1:0] resultSrc,
    input  logic [1:0] addrLow,
    input  logic       dmemReady,
    output logic       dmemReq,
    output logic       stall,
    output logic       complete,
    output logic       fault
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

    logic [0:0]    stateReg, stateNext;
    logic [CW-1:0] cntReg, cntNext;
    logic          reqComb, stallComb;
    logic          acc, misaligned;

    assign acc        = memWrite | (resultSrc == RES_MEM);
    assign misaligned = (addrLow != 2'b00);

    always_comb begin
        reqComb   = 1'b0;
        stallComb = 1'b0;
        complete  = 1'b0;
        fault     = 1'b0;
        stateNext = stateReg;
        cntNext   = cntReg;
        if (stateReg == ST_WAIT) begin
            if (cntReg == TMO) begin
                // Give up: the request is withdrawn, so a late ready is ignored
                fault     = 1'b1;
                stateNext = ST_IDLE;
                cntNext   = '0;
            end else begin
                reqComb = 1'b1;
                if (dmemReady) begin
                    complete  = 1'b1;
                    stateNext = ST_IDLE;
                    cntNext   = '0;
                end else begin
                    stallComb = 1'b1;
                    cntNext   = cntReg + CW'(1);
                end
            end
        end else if (acc) begin
            if (misaligned) begin
                // Never reaches the bus; retire immediately as a fault
                fault = 1'b1;
            end else begin
                reqComb = 1'b1;
                if (dmemReady) begin
                    complete = 1'b1;
                end else begin
                    stallComb = 1'b1;
                    stateNext = ST_WAIT;
                    cntNext   = CW'(1);
                end
            end
        end
    end

    // Reset must silence the bus and release the pipeline without waiting for a clock
    assign dmemReq = reqComb & ~rst;
    assign stall   = stallComb & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg <= ST_IDLE;
            cntReg   <= '0;
        end else begin
            stateReg <= stateNext;
            cntReg   <= cntNext;
        end
    end

endmodule

// File: rtl/memory_stage.sv
// memory_stage
//   Pipeline MEM stage: word loads/stores over the handshaked data bus,
//   StallM while an access is outstanding, MEM/WB register and ResultW mux.
//   Ports:
//     clk, rst                       clock, asynchronous active-high reset
//     ALUResultM..ResultSrcM         EX/MEM pipeline inputs
//     dmem                           data-memory bus (master side)
//     StallM                         hold PC/IF/ID/EX (combinational)
//     ALUResultW..FaultW             MEM/WB register outputs
//     ResultW                        writeback value, also fed to forwarding
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int                   TIMEOUT_CYCLES = 16,
    parameter logic [WORD_SIZE-1:0] FAULT_DATA     = 32'hDEADBEEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] ALUResultM,
    input  logic [WORD_SIZE-1:0] WriteDataM,
    input  logic [WORD_SIZE-1:0] PCPlus4M,
    input  logic [4:0]           RdM,
    input  logic                 RegWriteM,
    input  logic                 MemWriteM,
    input  logic [1:0]           ResultSrcM,
    memory_stage_if.master       dmem,
    output logic                 StallM,
    output logic [WORD_SIZE-1:0] ALUResultW,
    output logic [WORD_SIZE-1:0] ReadDataW,
    output logic [WORD_SIZE-1:0] PCPlus4W,
    output logic [4:0]           RdW,
    output logic                 RegWriteW,
    output logic [1:0]           ResultSrcW,
    output logic                 FaultW,
    output logic [WORD_SIZE-1:0] ResultW
);

    logic reqInt, lsuComplete, lsuFault;

    memory_stage_lsu_ctrl #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_lsu_ctrl (
        .clk       (clk),
        .rst       (rst),
        .memWrite  (MemWriteM),
        .resultSrc (ResultSrcM),
        .addrLow   (ALUResultM[1:0]),
        .dmemReady (dmem.dmem_ready),
        .dmemReq   (reqInt),
        .stall     (StallM),
        .complete  (lsuComplete),
        .fault     (lsuFault)
    );

    // Address and data come straight from the EX/MEM register; StallM keeps them stable
    assign dmem.dmem_req   = reqInt;
    assign dmem.dmem_we    = MemWriteM & reqInt;
    assign dmem.dmem_addr  = ALUResultM;
    assign dmem.dmem_wdata = WriteDataM;

    // MEM/WB register. Bubbles only need RegWriteW/RdW cleared; the other
    // fields are left as they were.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ALUResultW <= '0;
            ReadDataW  <= '0;
            PCPlus4W   <= '0;
            RdW        <= '0;
            RegWriteW  <= 1'b0;
            ResultSrcW <= '0;
            FaultW     <= 1'b0;
        end else if (StallM) begin
            RegWriteW <= 1'b0;
            RdW       <= '0;
            FaultW    <= 1'b0;
        end else if (lsuFault) begin
            RegWriteW <= 1'b0;
            RdW       <= '0;
            FaultW    <= 1'b1;
            ReadDataW <= FAULT_DATA;
        end else begin
            ALUResultW <= ALUResultM;
            PCPlus4W   <= PCPlus4M;
            RdW        <= RdM;
            RegWriteW  <= RegWriteM;
            ResultSrcW <= ResultSrcM;
            FaultW     <= 1'b0;
            // Stores and non-memory ops leave the last load data in place
            if (lsuComplete && !MemWriteM) begin
                ReadDataW <= dmem.dmem_rdata;
            end
        end
    end

    assign ResultW = resultMux(ResultSrcW, ALUResultW, ReadDataW, PCPlus4W);

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage
//   Directed bench for memory_stage. Stimulus pushes the expected writeback
//   record into a queue; a monitor pops and compares whenever a writeback
//   (RegWriteW or FaultW) appears. Bus/stall behaviour is checked inline.
module tb_memory_stage;

    typedef struct packed {
        logic        isFault;
        logic [4:0]  rd;
        logic [31:0] value;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic        StallM;
    logic [31:0] ALUResultW, ReadDataW, PCPlus4W, ResultW;
    logic [4:0]  RdW;
    logic        RegWriteW, FaultW;
    logic [1:0]  ResultSrcW;

    int   checks = 0;
    int   errors = 0;
    exp_t expQ[$];
    exp_t monE;
    logic monOk;

    memory_stage_if dmem();

    memory_stage #(.TIMEOUT_CYCLES(16), .FAULT_DATA(32'hDEADBEEF)) dut (
        .clk(clk), .rst(rst),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
        .RdM(RdM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .dmem(dmem), .StallM(StallM),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
        .RdW(RdW), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .FaultW(FaultW), .ResultW(ResultW)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic nop();
        ALUResultM = '0; WriteDataM = '0; PCPlus4M = '0; RdM = '0;
        RegWriteM = 1'b0; MemWriteM = 1'b0; ResultSrcM = 2'b00;
    endtask

    task automatic issue(input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc4,
                         input logic [4:0] rd, input logic rw, input logic mw, input logic [1:0] rs);
        ALUResultM = alu; WriteDataM = wd; PCPlus4M = pc4; RdM = rd;
        RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs;
    endtask

    task automatic checkWZero(input string name);
        check(name, 32'({ALUResultW, ReadDataW, PCPlus4W, RdW, RegWriteW, ResultSrcW, FaultW} != 0), 32'd0);
    endtask

    // Non-memory op: one cycle in MEM, no bus request, no stall
    task automatic runAlu(input string name, input logic [31:0] alu, input logic [31:0] pc4,
                          input logic [4:0] rd, input logic [1:0] rs, input logic [31:0] expVal);
        issue(alu, 32'h0, pc4, rd, 1'b1, 1'b0, rs);
        expQ.push_back('{isFault: 1'b0, rd: rd, value: expVal});
        @(negedge clk);
        check({name, "_req"}, 32'(dmem.dmem_req), 32'd0);
        check({name, "_stall"}, 32'(StallM), 32'd0);
        $display("ALU %s rd=%0d alu=%h pc4=%h sel=%b", name, rd, alu, pc4, rs);
        @(posedge clk); #1;
        nop();
    endtask

    // Memory op already on the M inputs: count stall cycles, check the bus
    // is held stable while stalled, and supply ready after readyAfter stalls.
    task automatic runAccess(input string name, input bit giveReady, input int readyAfter,
                             input int expStalls, input bit expReqFinal,
                             input logic [31:0] addr, input logic expWe, input logic [31:0] wdata);
        int stalls = 0;
        dmem.dmem_ready = giveReady && (readyAfter == 0);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!StallM) break;
            stalls++;
            check({name, "_req"}, 32'(dmem.dmem_req), 32'd1);
            check({name, "_addr"}, dmem.dmem_addr, addr);
            check({name, "_we"}, 32'(dmem.dmem_we), 32'(expWe));
            check({name, "_wdata"}, dmem.dmem_wdata, wdata);
            if (stalls >= 2) check({name, "_bubble_regwrite"}, 32'(RegWriteW), 32'd0);
            @(posedge clk); #1;
            if (giveReady && stalls == readyAfter) dmem.dmem_ready = 1'b1;
        end
        check({name, "_stall_cycles"}, 32'(stalls), 32'(expStalls));
        check({name, "_req_final"}, 32'(dmem.dmem_req), 32'(expReqFinal));
        if (expReqFinal) check({name, "_we_final"}, 32'(dmem.dmem_we), 32'(expWe));
        $display("MEM %s addr=%h we=%b stalls=%0d", name, addr, expWe, stalls);
        @(posedge clk); #1;
        dmem.dmem_ready = 1'b0;
        nop();
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst && (RegWriteW || FaultW)) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("FAIL unexpected_wb actual RdW=%0d ResultW=%h FaultW=%b required none",
                         RdW, ResultW, FaultW);
            end else begin
                monE = expQ.pop_front();
                if (monE.isFault)
                    monOk = FaultW && !RegWriteW && (RdW == 5'd0) && (ReadDataW == monE.value);
                else
                    monOk = !FaultW && RegWriteW && (RdW == monE.rd) && (ResultW == monE.value);
                if (!monOk) begin
                    errors++;
                    $display("FAIL wb actual RdW=%0d RegWriteW=%b FaultW=%b ResultW=%h ReadDataW=%h required fault=%b rd=%0d value=%h",
                             RdW, RegWriteW, FaultW, ResultW, ReadDataW, monE.isFault, monE.rd, monE.value);
                end else begin
                    $display("WB rd=%0d result=%h readdata=%h fault=%b ok", RdW, ResultW, ReadDataW, FaultW);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        nop();
        dmem.dmem_ready = 1'b0;
        dmem.dmem_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkWZero("reset_w_outputs");
        check("reset_req", 32'(dmem.dmem_req), 32'd0);
        check("reset_stall", 32'(StallM), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // ALU op
        runAlu("alu_rd5", 32'h10, 32'h4, 5'd5, 2'b00, 32'h10);
        // PC+4 select, with a stray ready that must be ignored
        dmem.dmem_ready = 1'b1;
        dmem.dmem_rdata = 32'h99999999;
        runAlu("pc4_rd1", 32'h20, 32'h1004, 5'd1, 2'b10, 32'h1004);
        dmem.dmem_ready = 1'b0;
        // Reserved select behaves like ALU
        runAlu("rsv_rd6", 32'h33, 32'h2000, 5'd6, 2'b11, 32'h33);

        // Zero-wait load
        dmem.dmem_rdata = 32'hCAFEF00D;
        issue(32'h100, 32'h0, 32'h0, 5'd7, 1'b1, 1'b0, 2'b01);
        expQ.push_back('{isFault: 1'b0, rd: 5'd7, value: 32'hCAFEF00D});
        runAccess("load0", 1'b1, 0, 0, 1'b1, 32'h100, 1'b0, 32'h0);

        // Store with 3 wait states: no writeback record expected
        issue(32'h104, 32'h55, 32'h0, 5'd0, 1'b0, 1'b1, 2'b00);
        runAccess("store3", 1'b1, 3, 3, 1'b1, 32'h104, 1'b1, 32'h55);

        // Load with 2 wait states
        dmem.dmem_rdata = 32'h12345678;
        issue(32'h10C, 32'h0, 32'h0, 5'd10, 1'b1, 1'b0, 2'b01);
        expQ.push_back('{isFault: 1'b0, rd: 5'd10, value: 32'h12345678});
        runAccess("load2", 1'b1, 2, 2, 1'b1, 32'h10C, 1'b0, 32'h0);

        // Load that never gets ready: timeout fault
        issue(32'h108, 32'h0, 32'h0, 5'd9, 1'b1, 1'b0, 2'b01);
        expQ.push_back('{isFault: 1'b1, rd: 5'd0, value: 32'hDEADBEEF});
        runAccess("timeout", 1'b0, 0, 16, 1'b0, 32'h108, 1'b0, 32'h0);

        // Misaligned load: no request, immediate fault, next ALU op unaffected
        issue(32'h102, 32'h0, 32'h0, 5'd11, 1'b1, 1'b0, 2'b01);
        expQ.push_back('{isFault: 1'b1, rd: 5'd0, value: 32'hDEADBEEF});
        runAccess("misaligned", 1'b0, 0, 0, 1'b0, 32'h102, 1'b0, 32'h0);
        runAlu("after_fault", 32'h77, 32'h0, 5'd3, 2'b00, 32'h77);

        // Reset in the middle of a waiting load
        issue(32'h200, 32'h0, 32'h0, 5'd4, 1'b1, 1'b0, 2'b01);
        repeat (3) @(negedge clk);
        check("midwait_stall_before", 32'(StallM), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midwait_rst_req", 32'(dmem.dmem_req), 32'd0);
        check("midwait_rst_stall", 32'(StallM), 32'd0);
        checkWZero("midwait_rst_w_outputs");
        $display("RST mid-wait asserted");
        nop();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        runAlu("after_reset", 32'hABC, 32'h0, 5'd2, 2'b00, 32'hABC);

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(expQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
